// File: rtl/fsm3onehot_bit_tx_if.sv
// Word handshake between a stimulus source and the serial bit transmitter.
interface fsm3onehot_bit_tx_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  // Source side: offers words and watches ready.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  // Transmitter side: consumes words and drives ready.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/fsm3onehot_bit_tx.sv
// Serial stimulus transmitter for the one-hot A/B/C/D sequence detector.
// Words are shifted out MSB first, one bit per cycle, while a registered
// one-hot mirror of the detector tracks the state each bit is applied to.
// At the end of every word the number of D entries it caused is reported.
module fsm3onehot_bit_tx #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  fsm3onehot_bit_tx_if.slave in_if,
  input  logic             clr,
  output logic             bit_valid,
  output logic             din,
  output logic [3:0]       state,
  output logic [3:0]       next_state,
  output logic             dout,
  output logic             done,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [3:0] ST_A = 4'b0001;
  localparam logic [3:0] ST_B = 4'b0010;
  localparam logic [3:0] ST_C = 4'b0100;
  localparam logic [3:0] ST_D = 4'b1000;

  typedef enum logic {
    IDLE,
    SHIFT
  } ctrl_t;

  ctrl_t            ctrl_q;
  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] acc_q;
  logic [CNT_W-1:0] match_q;
  logic             done_q;
  logic [3:0]       mirror_q;

  logic             last_bit;
  logic             accept;
  logic             count_hit;

  // The final bit of a word is on din when one bit remains; a new word may
  // be accepted in that cycle so consecutive words run without a bubble.
  assign last_bit        = (ctrl_q == SHIFT) && (cnt_q == CNT_W'(1));
  assign in_if.in_ready  = (ctrl_q == IDLE) || last_bit;
  assign accept          = in_if.in_valid && in_if.in_ready;

  assign bit_valid   = (ctrl_q == SHIFT);
  assign din         = shift_q[WIDTH-1];
  assign state       = mirror_q;
  assign dout        = mirror_q[3];
  assign done        = done_q;
  assign match_count = match_q;

  // A bit emitted while clr is high is not counted, since the mirror is
  // forced to A instead of following the bit.
  assign count_hit = bit_valid && (next_state == ST_D) && !clr;

  // Detector transition function applied to the current mirror and din.
  always_comb begin
    next_state = ST_A;
    case (mirror_q)
      ST_A:    next_state = din ? ST_B : ST_A;
      ST_B:    next_state = din ? ST_B : ST_C;
      ST_C:    next_state = din ? ST_D : ST_A;
      ST_D:    next_state = din ? ST_B : ST_C;
      default: next_state = ST_A;
    endcase
  end

  // Control FSM with shift register, bit counter and per-word D counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q  <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      match_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (accept) begin
        ctrl_q  <= SHIFT;
        shift_q <= in_if.in_data;
        cnt_q   <= CNT_W'(WIDTH);
      end else if (ctrl_q == SHIFT) begin
        shift_q <= shift_q << 1;
        cnt_q   <= cnt_q - CNT_W'(1);
        if (last_bit) begin
          ctrl_q  <= IDLE;
          shift_q <= '0;
        end
      end

      // The total is captured as the last bit leaves; a following word's
      // first bit appears after this edge and so counts into a fresh total.
      if (last_bit) begin
        match_q <= acc_q + CNT_W'(count_hit);
        acc_q   <= '0;
        done_q  <= 1'b1;
      end else if (count_hit) begin
        acc_q <= acc_q + CNT_W'(1);
      end
    end
  end

  // Detector mirror: follows each valid bit, clr returns it to A at any time.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mirror_q <= ST_A;
    end else if (clr) begin
      mirror_q <= ST_A;
    end else if (bit_valid) begin
      mirror_q <= next_state;
    end
  end

endmodule
